// File: rtl/transmit_arbiter.sv
// transmit_arbiter: round-robin arbiter that hands one requester's payload at a
// time to a serial transmitter, with a watchdog on the transmitter's busy flag.
//
// Handshake: each requester holds its req bit high (with stable req_data) until
// it sees a one-cycle req_ack pulse on its bit; the payload is latched at the
// edge that enters LATCH, so dropping req before that edge means it is skipped.
// Toward the transmitter, tx_start is a one-cycle pulse with tx_data stable; the
// transmitter answers by raising tx_busy and lowering it when the frame is done.
module transmit_arbiter #(
  parameter int DATA_W        = 64,
  parameter int START_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] req_data0,
  input  logic [DATA_W-1:0] req_data1,
  input  logic [DATA_W-1:0] req_data2,
  input  logic [DATA_W-1:0] req_data3,
  output logic [3:0]        req_ack,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic [1:0]        grant_id,
  output logic              active,
  output logic              err_timeout,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LATCH     = 3'd1,
    S_START     = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_DONE = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_last_grant;
  logic [1:0]        r_grant_id;
  logic [DATA_W-1:0] r_tx_data;
  logic [7:0]        r_cnt;
  logic              r_err;

  logic [1:0]        w_base;
  logic [3:0]        w_rot;
  logic [1:0]        w_offset;
  logic [1:0]        w_winner;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_timeout_hit;

  // Search starts one past the last winner and wraps around.
  assign w_base        = r_last_grant + 2'd1;
  assign w_winner      = w_base + w_offset;
  assign w_timeout_hit = (r_cnt == 8'(START_TIMEOUT - 1));

  // Rotate the request vector so bit 0 is the first candidate in search order.
  always_comb begin
    w_rot = req;
    case (w_base)
      2'd0: w_rot = req;
      2'd1: w_rot = {req[0],   req[3:1]};
      2'd2: w_rot = {req[1:0], req[3:2]};
      2'd3: w_rot = {req[2:0], req[3]};
      default: w_rot = req;
    endcase
  end

  // Lowest set bit of the rotated vector is the distance from the search start.
  always_comb begin
    w_offset = 2'd3;
    if (w_rot[0])      w_offset = 2'd0;
    else if (w_rot[1]) w_offset = 2'd1;
    else if (w_rot[2]) w_offset = 2'd2;
  end

  // Payload mux for the winning requester.
  always_comb begin
    w_sel_data = req_data0;
    case (w_winner)
      2'd0: w_sel_data = req_data0;
      2'd1: w_sel_data = req_data1;
      2'd2: w_sel_data = req_data2;
      2'd3: w_sel_data = req_data3;
      default: w_sel_data = req_data0;
    endcase
  end

  // Next-state logic and state-decoded pulses (ack only in LATCH, start only in START).
  always_comb begin
    w_next   = r_state;
    req_ack  = 4'b0000;
    tx_start = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((req != 4'b0000) && !tx_busy) w_next = S_LATCH;
      end
      S_LATCH: begin
        req_ack = 4'b0001 << r_grant_id;
        w_next  = S_START;
      end
      S_START: begin
        tx_start = 1'b1;
        w_next   = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx_busy)            w_next = S_WAIT_DONE;
        else if (w_timeout_hit) w_next = S_IDLE;
      end
      S_WAIT_DONE: begin
        if (!tx_busy) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register, grant capture, busy watchdog counter and timeout pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 2'd3;
      r_grant_id   <= 2'd0;
      r_tx_data    <= '0;
      r_cnt        <= 8'd0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= 1'b0;
      // The grant decision and payload capture happen together, so a request
      // withdrawn before this edge can never be latched.
      if ((r_state == S_IDLE) && (w_next == S_LATCH)) begin
        r_tx_data    <= w_sel_data;
        r_grant_id   <= w_winner;
        r_last_grant <= w_winner;
      end
      if (r_state == S_START) begin
        r_cnt <= 8'd0;
      end else if ((r_state == S_WAIT_BUSY) && !tx_busy) begin
        if (w_timeout_hit) r_err <= 1'b1;  // word is dropped, not retried
        else               r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign tx_data     = r_tx_data;
  assign grant_id    = r_grant_id;
  assign active      = (r_state != S_IDLE);
  assign err_timeout = r_err;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_transmit_arbiter.sv
// Bench for transmit_arbiter: directed scenarios, a transaction-timeline model
// compared every cycle, plus hand-computed literal checks.
module tb_transmit_arbiter;
  localparam int DW = 64;
  localparam int T  = 16;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [3:0]    req = 4'b0000;
  logic [DW-1:0] dat [4];
  logic [3:0]    req_ack;
  logic [DW-1:0] tx_data;
  logic          tx_start;
  logic          tx_busy;
  logic [1:0]    grant_id;
  logic          active;
  logic          err_timeout;
  logic [2:0]    dbg_state;

  always #5 clk = ~clk;

  transmit_arbiter #(.DATA_W(DW), .START_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .req(req),
    .req_data0(dat[0]), .req_data1(dat[1]), .req_data2(dat[2]), .req_data3(dat[3]),
    .req_ack(req_ack), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .grant_id(grant_id), .active(active), .err_timeout(err_timeout),
    .dbg_state(dbg_state)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp_v);
    end
  endtask

  // ---------------- serial transmitter model ----------------
  // Raises busy one cycle after it sees tx_start and holds it hold_len cycles.
  logic gen_busy   = 1'b0;
  logic force_busy = 1'b0;
  bit   xmit_en    = 1'b1;
  bit   pend       = 1'b0;
  int   hold_len   = 70;
  int   hold_cnt   = 0;
  int   busy_fall_cyc = -1;

  assign tx_busy = gen_busy | force_busy;

  always @(negedge clk) begin
    if (pend) begin
      gen_busy = 1'b1;
      pend     = 1'b0;
      hold_cnt = hold_len;
    end else if (gen_busy) begin
      hold_cnt--;
      if (hold_cnt == 0) begin
        gen_busy      = 1'b0;
        busy_fall_cyc = cyc;
      end
    end
    if (tx_start === 1'b1 && xmit_en) pend = 1'b1;
  end

  // ---------------- reference model ----------------
  // m_age counts cycles since a grant was decided: 1 = ack cycle, 2 = start
  // cycle, 3+ = waiting on the transmitter; -1 = no frame in progress.
  int            m_age  = -1;
  logic [1:0]    m_win  = 2'd0;
  logic [1:0]    m_gid  = 2'd0;
  logic [1:0]    m_last = 2'd3;
  logic [DW-1:0] m_data = '0;
  bit            m_seen = 1'b0;
  int            m_wait = 0;
  bit            m_err  = 1'b0;

  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    for (int k = 1; k <= 4; k++)
      if (r[(int'(last) + k) % 4]) return 2'((int'(last) + k) % 4);
    return 2'd0;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m_age <= -1; m_last <= 2'd3; m_gid <= 2'd0; m_data <= '0;
      m_err <= 1'b0; m_seen <= 1'b0; m_wait <= 0;
    end else begin
      m_err <= 1'b0;
      if (m_age < 0) begin
        if (req != 4'b0000 && !tx_busy) begin
          m_win  <= rr_pick(req, m_last);
          m_gid  <= rr_pick(req, m_last);
          m_last <= rr_pick(req, m_last);
          m_data <= dat[rr_pick(req, m_last)];
          m_age  <= 1;
        end
      end else if (m_age < 3) begin
        m_age  <= m_age + 1;
        m_seen <= 1'b0;
        m_wait <= 0;
      end else if (!m_seen) begin
        if (tx_busy)               m_seen <= 1'b1;
        else if (m_wait + 1 == T) begin m_age <= -1; m_err <= 1'b1; end
        else                       m_wait <= m_wait + 1;
      end else if (!tx_busy) begin
        m_age <= -1;
      end
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ack",     64'(req_ack),     (m_age == 1) ? 64'(4'b0001 << m_win) : 64'd0);
      chk("tx_start",    64'(tx_start),    64'(m_age == 2));
      chk("active",      64'(active),      64'(m_age >= 1));
      chk("err_timeout", 64'(err_timeout), 64'(m_err));
      chk("grant_id",    64'(grant_id),    64'(m_gid));
      chk("tx_data",     tx_data,          m_data);
    end
  end

  // ---------------- driver tasks ----------------
  function automatic int oh2i(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic wait_ack(input int maxc, input bit drop, output int idx, output int at);
    idx = -1; at = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (req_ack != 4'b0000) begin
        idx = oh2i(req_ack); at = cyc;
        if (drop && idx >= 0) req[idx] = 1'b0;
        return;
      end
    end
    chk("wait_ack_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_start(input int maxc, output int at, output logic [DW-1:0] d);
    at = -1; d = '0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (tx_start) begin at = cyc; d = tx_data; return; end
    end
    chk("wait_start_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_err(input int maxc, output int at);
    at = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (err_timeout) begin at = cyc; return; end
    end
    chk("wait_err_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_idle(input int maxc, output int at);
    at = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (!active) begin at = cyc; return; end
    end
    chk("wait_idle_timeout", 64'd0, 64'd1);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int idx, ac, sc, ec, ic, rc, n_ack;
    logic [DW-1:0] sd;
    int log_q[$];
    int exp2[5] = '{0, 1, 2, 3, 0};
    int exp3[3] = '{3, 1, 3};

    dat[0] = 64'hA5A5_0000_0000_0001;
    dat[1] = 64'h1111_2222_3333_4444;
    dat[2] = 64'hCAFE_F00D_0000_0002;
    dat[3] = 64'hDEAD_BEEF_0000_0003;

    // reset state
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_active",   64'(active),   64'd0);
    chk("rst_grant_id", 64'(grant_id), 64'd0);
    chk("rst_tx_data",  tx_data,       64'd0);
    chk("rst_req_ack",  64'(req_ack),  64'd0);
    rst = 1'b1;

    // single requester, transmitter busy for 70 cycles
    hold_len = 70;
    @(negedge clk); req = 4'b0001; rc = cyc;
    wait_ack(10, 1'b1, idx, ac);
    chk("t1_ack_idx", 64'(idx), 64'd0);
    chk("t1_ack_lat", 64'(ac - rc), 64'd1);
    wait_start(10, sc, sd);
    chk("t1_start_lat", 64'(sc - rc), 64'd2);
    chk("t1_tx_data", sd, 64'hA5A5_0000_0000_0001);
    wait_idle(200, ic);
    chk("t1_active_after_busy", 64'(ic - busy_fall_cyc), 64'd1);

    // all four requesting: 0,1,2,3,0
    do_reset();
    hold_len = 3;
    @(negedge clk); req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ack(50, 1'b0, idx, ac);
      log_q.push_back(idx);
    end
    req = 4'b0000;
    for (int k = 0; k < 5; k++) chk($sformatf("t2_grant%0d", k), 64'(log_q[k]), 64'(exp2[k]));
    wait_idle(50, ic);

    // 1010 after last_grant = 1: 3,1,3
    do_reset();
    @(negedge clk); req = 4'b0010;
    wait_ack(10, 1'b1, idx, ac);
    chk("t3_first_idx", 64'(idx), 64'd1);
    wait_idle(50, ic);
    @(negedge clk); req = 4'b1010;
    log_q.delete();
    for (int k = 0; k < 3; k++) begin
      wait_ack(50, 1'b0, idx, ac);
      log_q.push_back(idx);
    end
    req = 4'b0000;
    for (int k = 0; k < 3; k++) chk($sformatf("t3_grant%0d", k), 64'(log_q[k]), 64'(exp3[k]));
    wait_idle(50, ic);

    // transmitter never answers: timeout, word dropped, re-grant
    xmit_en = 1'b0;
    @(negedge clk); req = 4'b0001;
    wait_ack(10, 1'b0, idx, ac);
    wait_start(10, sc, sd);
    wait_err(T + 10, ec);
    chk("t4_err_delay", 64'(ec - (sc + 1)), 64'(T));
    wait_ack(10, 1'b1, idx, ac);
    chk("t4_regrant_idx", 64'(idx), 64'd0);
    chk("t4_regrant_lat", 64'(ac - ec), 64'd1);
    wait_err(T + 10, ec);
    wait_idle(10, ic);
    xmit_en = 1'b1;

    // reset while waiting for the transmitter to finish
    do_reset();
    hold_len = 40;
    @(negedge clk); req = 4'b0001;
    wait_ack(10, 1'b1, idx, ac);
    wait_start(10, sc, sd);
    req[3] = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_mid_frame", 64'({active, tx_busy}), 64'd3);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_rst_active",   64'(active),   64'd0);
    chk("t5_rst_grant_id", 64'(grant_id), 64'd0);
    chk("t5_rst_tx_data",  tx_data,       64'd0);
    rst = 1'b1;
    wait_ack(100, 1'b1, idx, ac);
    chk("t5_idx", 64'(idx), 64'd3);
    chk("t5_after_busy", 64'(ac > busy_fall_cyc), 64'd1);
    wait_idle(100, ic);

    // transmitter busy from an external source
    do_reset();
    hold_len = 3;
    force_busy = 1'b1;
    @(negedge clk); req = 4'b0100;
    n_ack = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (req_ack != 4'b0000) n_ack++;
    end
    chk("t6_no_ack_while_busy", 64'(n_ack), 64'd0);
    force_busy = 1'b0;
    wait_ack(10, 1'b1, idx, ac);
    chk("t6_idx", 64'(idx), 64'd2);
    wait_idle(50, ic);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // watchdog
  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
